fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 17 +
 rtl/fetch_unit_bht.sv | 22 ++
 rtl/fetch_unit.sv | 78 +++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared next-PC select codes, reset constants and predictor parameters.
package fetch_unit_pkg;
    typedef enum logic [1:0] {
        SEL_PC4  = 2'b00,
        SEL_JUMP = 2'b01,
        SEL_BR   = 2'b10,
        SEL_CORR = 2'b11
    } addr_sel_t;
    localparam logic [31:0] NOP       = 32'h0000_0000;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          BHT_DEPTH = 16;
    localparam int          BHT_IDX_W = $clog2(BHT_DEPTH);
    localparam logic [1:0]  CNT_RESET = 2'b01;
    function automatic logic [1:0] sat_count(input logic [1:0] c, input logic up);
        return up ? ((c == 2'b11) ? c : c + 2'd1) : ((c == 2'b00) ? c : c - 2'd1);
    endfunction
endpackage

// File: rtl/fetch_unit_bht.sv
// branch_hist_table: 2-bit saturating counter table; read returns the pre-update prediction bit.
module branch_hist_table
    import fetch_unit_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [BHT_IDX_W-1:0] rd_idx,
    input  logic [BHT_IDX_W-1:0] wr_idx,
    input  logic                 wr_en,
    input  logic                 outcome,
    output logic                 pred
);
    logic [1:0] cnt [BHT_DEPTH];
    assign pred = cnt[rd_idx][1];
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) cnt[i] <= CNT_RESET;
        end else if (wr_en) begin
            cnt[wr_idx] <= sat_count(cnt[wr_idx], outcome);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, next-PC mux, IF/ID pipeline register and branch predictor
// with misprediction detection and correction-address generation.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic        PC_Write,
    input  logic        IF_Write,
    input  logic        IF_Flush,
    input  logic [1:0]  addrSel,
    input  logic [31:0] jumpAddr,
    input  logic [31:0] brTarget,
    input  logic        brID,
    input  logic [31:0] instrIn,
    input  logic        brResolve,
    input  logic        brOutcome,
    output logic [31:0] pc,
    output logic [31:0] instrID,
    output logic [31:0] pcPlus4ID,
    output logic        taken,
    output logic        needFlush
);
    addr_sel_t            sel;
    logic [31:0]          pc_plus4, corr_addr, next_pc;
    logic [31:0]          saved_target, saved_fall;
    logic [BHT_IDX_W-1:0] idx, saved_idx;
    logic                 pred, pred_bit;
    // (pcPlus4ID-4)[5:2] is pcPlus4ID[5:2]-1, since subtracting 4 leaves bits [1:0] untouched
    assign idx       = pcPlus4ID[5:2] - 4'd1;
    assign sel       = addr_sel_t'(addrSel);
    assign pc_plus4  = pc + 32'd4;
    assign taken     = brID & pred;
    assign needFlush = brResolve & (brOutcome != pred_bit);
    assign corr_addr = pred_bit ? saved_fall : saved_target;
    assign next_pc   = (sel == SEL_PC4)  ? pc_plus4 :
                       (sel == SEL_JUMP) ? jumpAddr :
                       (sel == SEL_BR)   ? brTarget : corr_addr;
    branch_hist_table u_bht (
        .Clk     (Clk),
        .Rst     (Rst),
        .rd_idx  (idx),
        .wr_idx  (saved_idx),
        .wr_en   (brResolve),
        .outcome (brOutcome),
        .pred    (pred)
    );
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            pc        <= RESET_PC;
            instrID   <= NOP;
            pcPlus4ID <= 32'h0;
        end else begin
            if (PC_Write) pc <= next_pc;
            if (IF_Flush) begin
                instrID   <= NOP;
                pcPlus4ID <= 32'h0;
            end else if (IF_Write) begin
                instrID   <= instrIn;
                pcPlus4ID <= pc_plus4;
            end
        end
    end
    // Saved branch context is only replaced when the fetch stream advances
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            pred_bit     <= 1'b0;
            saved_target <= 32'h0;
            saved_fall   <= 32'h0;
            saved_idx    <= '0;
        end else if (brID && PC_Write) begin
            pred_bit     <= taken;
            saved_target <= brTarget;
            saved_fall   <= pcPlus4ID;
            saved_idx    <= idx;
        end
    end
endmodule
